parallax_layer_engine: RTL and testbench

- Parametrised N-layer scrolling-checkerboard renderer for the TinyVGA output path; successor to the fixed five-layer parallax demo.
- Sits between the hsync/vsync generator and the PMOD pin mapping.
- Per-layer velocity, tile size, dither pattern, colour and enable are runtime-programmable through a valid/ready config port, with tear-free commit at frame start.
- Runs entirely on clk; no vsync-clocked logic. RGB output is pipelined by 2 cycles.

---
 rtl/parallax_layer_engine_if.sv | 20 ++
 rtl/parallax_layer_engine.sv | 149 ++++++++++++++
 tb/tb_parallax_layer_engine.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/parallax_layer_engine_if.sv
// Configuration write port for the parallax layer engine: valid/ready write
// request plus a one-cycle error pulse for writes that address nothing.
interface parallax_layer_engine_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_layer;
    logic [2:0] cfg_field;
    logic [7:0] cfg_data;
    logic       cfg_err;

    modport master (
        output cfg_valid, cfg_layer, cfg_field, cfg_data,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_layer, cfg_field, cfg_data,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/parallax_layer_engine.sv
// N-layer scrolling checkerboard renderer with shadow/active config registers
// committed at frame start and a 2-cycle registered RGB pipeline.
module parallax_layer_engine #(
    parameter int                 NUM_LAYERS = 5,
    parameter int                 COORD_W    = 10,
    parameter int                 FRAC       = 2,
    parameter int                 COLOR_W    = 6,
    parameter logic [COLOR_W-1:0] BG_COLOR   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [COORD_W-1:0]    pix_x,
    input  logic [COORD_W-1:0]    pix_y,
    input  logic                  video_active,
    input  logic                  frame_start,
    input  logic                  pause,
    parallax_layer_engine_if.slave cfg,
    output logic [COLOR_W-1:0]    rgb,
    output logic                  rgb_active
);
    localparam int OFS_W  = COORD_W + FRAC;
    localparam int TS_MAX = COORD_W - 1;

    logic cfg_accept;
    logic cfg_addr_ok;
    logic cfg_err_reg;

    // Writes are refused during the commit cycle so a shadow update never races the copy.
    assign cfg.cfg_ready = ~frame_start;
    assign cfg_accept    = cfg.cfg_valid & ~frame_start;
    assign cfg_addr_ok   = (32'(cfg.cfg_layer) < NUM_LAYERS) && (cfg.cfg_field <= 3'd5);
    assign cfg.cfg_err   = cfg_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cfg_err_reg <= 1'b0;
        else        cfg_err_reg <= cfg_accept & ~cfg_addr_ok;
    end

    // Dither pass for codes 0..3, shared by every layer.
    logic [3:0] dpass_vec;
    assign dpass_vec = {pix_x[0] ^ pix_y[0], ~pix_y[0] ^ pix_x[1], pix_y[1] ^ pix_x[0], 1'b1};

    logic [NUM_LAYERS-1:0]              hit_next;
    logic [NUM_LAYERS-1:0][COLOR_W-1:0] layer_color;

    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
        localparam logic [7:0]         VX_RST  = 8'((gi + 1) << FRAC);
        localparam logic [7:0]         VY_RST  = 8'(gi << FRAC);
        localparam logic [3:0]         TS_RST  = (8 - gi > 3) ? 4'(8 - gi) : 4'd3;
        localparam logic [COLOR_W-1:0] COL_RST = COLOR_W'({COLOR_W{1'b1}} >> gi);

        logic [7:0]         sh_vx_reg, sh_vy_reg, act_vx_reg, act_vy_reg;
        logic [3:0]         sh_ts_reg, act_ts_reg;
        logic [1:0]         sh_dith_reg, act_dith_reg;
        logic [COLOR_W-1:0] sh_col_reg, act_col_reg;
        logic               sh_en_reg, act_en_reg;
        logic [OFS_W-1:0]   ofs_x_reg, ofs_y_reg;
        logic               wr_sel;
        logic [COORD_W-1:0] lx, ly;
        logic [3:0]         ts;

        assign wr_sel = cfg_accept & cfg_addr_ok & (cfg.cfg_layer == 3'(gi));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sh_vx_reg   <= VX_RST;
                sh_vy_reg   <= VY_RST;
                sh_ts_reg   <= TS_RST;
                sh_dith_reg <= 2'd0;
                sh_col_reg  <= COL_RST;
                sh_en_reg   <= 1'b1;
            end else if (wr_sel) begin
                case (cfg.cfg_field)
                    3'd0:    sh_vx_reg   <= cfg.cfg_data;
                    3'd1:    sh_vy_reg   <= cfg.cfg_data;
                    3'd2:    sh_ts_reg   <= cfg.cfg_data[3:0];
                    3'd3:    sh_dith_reg <= cfg.cfg_data[1:0];
                    3'd4:    sh_col_reg  <= cfg.cfg_data[COLOR_W-1:0];
                    3'd5:    sh_en_reg   <= cfg.cfg_data[0];
                    default: ;
                endcase
            end
        end

        // Offsets advance by the velocity that was active during the frame just ended.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                act_vx_reg   <= VX_RST;
                act_vy_reg   <= VY_RST;
                act_ts_reg   <= TS_RST;
                act_dith_reg <= 2'd0;
                act_col_reg  <= COL_RST;
                act_en_reg   <= 1'b1;
                ofs_x_reg    <= '0;
                ofs_y_reg    <= '0;
            end else if (frame_start) begin
                act_vx_reg   <= sh_vx_reg;
                act_vy_reg   <= sh_vy_reg;
                act_ts_reg   <= sh_ts_reg;
                act_dith_reg <= sh_dith_reg;
                act_col_reg  <= sh_col_reg;
                act_en_reg   <= sh_en_reg;
                if (!pause) begin
                    ofs_x_reg <= ofs_x_reg + {{(OFS_W-8){act_vx_reg[7]}}, act_vx_reg};
                    ofs_y_reg <= ofs_y_reg + {{(OFS_W-8){act_vy_reg[7]}}, act_vy_reg};
                end
            end
        end

        assign lx = pix_x + ofs_x_reg[OFS_W-1:FRAC];
        assign ly = pix_y + ofs_y_reg[OFS_W-1:FRAC];
        assign ts = (act_ts_reg > 4'(TS_MAX)) ? 4'(TS_MAX) : act_ts_reg;

        assign hit_next[gi]    = act_en_reg & (lx[ts] ^ ly[ts]) & dpass_vec[act_dith_reg];
        assign layer_color[gi] = act_col_reg;
    end

    logic [NUM_LAYERS-1:0] hit_reg;
    logic                  vid_d1_reg;
    logic                  vid_d2_reg;
    logic [COLOR_W-1:0]    rgb_reg;
    logic [COLOR_W-1:0]    rgb_next;

    // Lowest index wins: scan from the back so nearer layers overwrite farther ones.
    always_comb begin
        rgb_next = BG_COLOR;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (hit_reg[i]) rgb_next = layer_color[i];
        end
        if (!vid_d1_reg) rgb_next = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_reg    <= '0;
            vid_d1_reg <= 1'b0;
            vid_d2_reg <= 1'b0;
            rgb_reg    <= '0;
        end else begin
            hit_reg    <= hit_next;
            vid_d1_reg <= video_active;
            vid_d2_reg <= vid_d1_reg;
            rgb_reg    <= rgb_next;
        end
    end

    assign rgb        = rgb_reg;
    assign rgb_active = vid_d2_reg;
endmodule

// File: tb/tb_parallax_layer_engine.sv
// Randomised self-checking bench for parallax_layer_engine against a
// frame-level reference model of layers, offsets and priority.
module tb_parallax_layer_engine;
    localparam int N = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] pix_x, pix_y;
    logic       video_active, frame_start, pause;
    logic [5:0] rgb;
    logic       rgb_active;

    parallax_layer_engine_if cfg_if ();

    parallax_layer_engine dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .video_active (video_active),
        .frame_start  (frame_start),
        .pause        (pause),
        .cfg          (cfg_if),
        .rgb          (rgb),
        .rgb_active   (rgb_active)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: shadow and active fields, offsets in 1/4 pixel units.
    int sh_vx[N], sh_vy[N], sh_ts[N], sh_dith[N], sh_col[N], sh_en[N];
    int ac_vx[N], ac_vy[N], ac_ts[N], ac_dith[N], ac_col[N], ac_en[N];
    int ofx[N], ofy[N];

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            sh_vx[i] = (i + 1) * 4;  sh_vy[i] = i * 4;
            sh_ts[i] = (8 - i > 3) ? 8 - i : 3;
            sh_dith[i] = 0;  sh_col[i] = 63 >> i;  sh_en[i] = 1;
            ac_vx[i] = sh_vx[i];  ac_vy[i] = sh_vy[i];  ac_ts[i] = sh_ts[i];
            ac_dith[i] = 0;  ac_col[i] = sh_col[i];  ac_en[i] = 1;
            ofx[i] = 0;  ofy[i] = 0;
        end
    endfunction

    function automatic int sext8(int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic void model_frame(bit p);
        for (int i = 0; i < N; i++) begin
            if (!p) begin
                ofx[i] = (ofx[i] + sext8(ac_vx[i])) & 4095;
                ofy[i] = (ofy[i] + sext8(ac_vy[i])) & 4095;
            end
            ac_vx[i] = sh_vx[i];  ac_vy[i] = sh_vy[i];  ac_ts[i] = sh_ts[i];
            ac_dith[i] = sh_dith[i];  ac_col[i] = sh_col[i];  ac_en[i] = sh_en[i];
        end
    endfunction

    function automatic void model_write(int l, int f, int d);
        if (l < N && f <= 5) begin
            case (f)
                0: sh_vx[l] = d & 255;
                1: sh_vy[l] = d & 255;
                2: sh_ts[l] = d & 15;
                3: sh_dith[l] = d & 3;
                4: sh_col[l] = d & 63;
                default: sh_en[l] = d & 1;
            endcase
        end
    endfunction

    function automatic int exp_rgb(int px, int py, bit va);
        int lx, ly, t, tb, dp;
        if (!va) return 0;
        for (int i = 0; i < N; i++) begin
            lx = (px + (ofx[i] >> 2)) % 1024;
            ly = (py + (ofy[i] >> 2)) % 1024;
            t  = (ac_ts[i] > 9) ? 9 : ac_ts[i];
            tb = ((lx >> t) & 1) ^ ((ly >> t) & 1);
            case (ac_dith[i])
                0: dp = 1;
                1: dp = ((py >> 1) & 1) ^ (px & 1);
                2: dp = (1 - (py & 1)) ^ ((px >> 1) & 1);
                default: dp = (px & 1) ^ (py & 1);
            endcase
            if (ac_en[i] == 1 && tb == 1 && dp == 1) return ac_col[i];
        end
        return 0;
    endfunction

    task automatic dut_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        frame_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic do_write(input int l, input int f, input int d);
        bit exp_err;
        @(negedge clk);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_layer = 3'(l);
        cfg_if.cfg_field = 3'(f);
        cfg_if.cfg_data  = 8'(d);
        exp_err = !(l < N && f <= 5);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        model_write(l, f, d);
        checks++;
        if (cfg_if.cfg_err !== exp_err) begin
            errors++;
            $display("FAIL cfg_err: write l=%0d f=%0d err=%b expected %b", l, f, cfg_if.cfg_err, exp_err);
        end else
            $display("ok   cfg write l=%0d f=%0d d=%02h err=%b", l, f, d, cfg_if.cfg_err);
        if (exp_err) begin
            @(negedge clk);
            checks++;
            if (cfg_if.cfg_err !== 1'b0) begin
                errors++;
                $display("FAIL cfg_err_width: err=%b expected 0 one cycle later", cfg_if.cfg_err);
            end
        end
    endtask

    task automatic do_frame(input bit p);
        @(negedge clk);
        pause = p;
        frame_start = 1'b1;
        #1;
        checks++;
        if (cfg_if.cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL cfg_ready_fs: ready=%b expected 0", cfg_if.cfg_ready);
        end
        @(negedge clk);
        frame_start = 1'b0;
        model_frame(p);
        $display("ok   frame_start pause=%b", p);
    endtask

    task automatic check_pixel(input int px, input int py, input bit va, input string name);
        int e;
        @(negedge clk);
        pix_x = 10'(px);  pix_y = 10'(py);  video_active = va;
        e = exp_rgb(px, py, va);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rgb !== 6'(e)) begin
            errors++;
            $display("FAIL %s: pix=(%0d,%0d) rgb=%b expected %b", name, px, py, rgb, 6'(e));
        end else
            $display("ok   %s: pix=(%0d,%0d) rgb=%b", name, px, py, rgb);
        checks++;
        if (rgb_active !== va) begin
            errors++;
            $display("FAIL %s_active: rgb_active=%b expected %b", name, rgb_active, va);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pix_x = '0;  pix_y = '0;  video_active = 1'b1;
        frame_start = 1'b0;  pause = 1'b0;
        cfg_if.cfg_valid = 1'b0;  cfg_if.cfg_layer = '0;
        cfg_if.cfg_field = '0;    cfg_if.cfg_data  = '0;
        #23;
        checks++;
        if (rgb !== 6'd0 || rgb_active !== 1'b0 || cfg_if.cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: rgb=%b act=%b err=%b expected 0/0/0", rgb, rgb_active, cfg_if.cfg_err);
        end else
            $display("ok   reset outputs clear");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        checks++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_idle: ready=%b expected 1", cfg_if.cfg_ready);
        end
    endtask

    task automatic test_basic_render();
        check_pixel(0, 0, 1'b1, "origin");
        check_pixel(256, 0, 1'b1, "layer0_tile");
        check_pixel(16, 0, 1'b1, "far_layer");
        check_pixel(0, 0, 1'b1, "origin_again");
    endtask

    task automatic test_scroll_pause();
        dut_reset();
        do_write(0, 0, 4);
        do_write(0, 1, 0);
        for (int k = 0; k < 3; k++) do_frame(1'b0);
        check_pixel(253, 0, 1'b1, "scroll_253");
        check_pixel(252, 0, 1'b1, "scroll_252");
        do_frame(1'b1);
        check_pixel(253, 0, 1'b1, "paused_253");
    endtask

    task automatic test_negative_wrap();
        dut_reset();
        do_write(0, 0, 8'hFC);
        for (int k = 0; k < 3; k++) do_frame(1'b0);
        check_pixel(1, 0, 1'b1, "wrap_1");
        check_pixel(0, 0, 1'b1, "wrap_0");
        check_pixel(257, 0, 1'b1, "wrap_257");
    endtask

    task automatic test_commit_timing();
        dut_reset();
        @(negedge clk);
        pause = 1'b1;
        frame_start = 1'b1;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_layer = 3'd0;  cfg_if.cfg_field = 3'd4;  cfg_if.cfg_data = 8'h15;
        #1;
        checks++;
        if (cfg_if.cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_during_fs: ready=%b expected 0", cfg_if.cfg_ready);
        end
        @(negedge clk);
        model_frame(1'b1);
        frame_start = 1'b0;
        #1;
        checks++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_fs: ready=%b expected 1", cfg_if.cfg_ready);
        end
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        model_write(0, 4, 8'h15);
        check_pixel(256, 0, 1'b1, "old_color_midframe");
        do_frame(1'b1);
        check_pixel(256, 0, 1'b1, "new_color_committed");
    endtask

    task automatic test_invalid_write();
        do_write(6, 4, 8'h00);
        do_write(0, 7, 8'h00);
        do_write(2, 6, 8'hFF);
        do_frame(1'b1);
        check_pixel(256, 0, 1'b1, "after_invalid");
        check_pixel(300, 40, 1'b1, "after_invalid_b");
    endtask

    task automatic test_dither_and_blank();
        for (int l = 0; l < 4; l++) do_write(l, 5, 0);
        do_write(4, 3, 3);
        do_frame(1'b1);
        check_pixel(16, 0, 1'b1, "dither_odd");
        check_pixel(17, 1, 1'b1, "dither_even");
        check_pixel(17, 0, 1'b1, "dither_x1");
        for (int k = 0; k < 10; k++)
            check_pixel($urandom_range(0, 1023), $urandom_range(0, 1023), 1'b1, "dither_rand");
        check_pixel(16, 0, 1'b0, "blank");
    endtask

    task automatic test_back_to_back(input int n);
        int exp_q[$];
        bit va_q[$];
        int e;
        bit ea;
        int px, py;
        bit va;
        for (int k = 0; k < n + 2; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                e  = exp_q.pop_front();
                ea = va_q.pop_front();
                checks++;
                if (rgb !== 6'(e) || rgb_active !== ea) begin
                    errors++;
                    $display("FAIL stream: rgb=%b act=%b expected %b/%b", rgb, rgb_active, 6'(e), ea);
                end else
                    $display("ok   stream rgb=%b act=%b", rgb, rgb_active);
            end
            if (k < n) begin
                px = $urandom_range(0, 1023);
                py = $urandom_range(0, 1023);
                va = ($urandom_range(0, 7) != 0);
                pix_x = 10'(px);  pix_y = 10'(py);  video_active = va;
                exp_q.push_back(exp_rgb(px, py, va));
                va_q.push_back(va);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < 5; w++) begin
                if ($urandom_range(0, 9) == 0)
                    do_write($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255));
                else
                    do_write($urandom_range(0, N - 1), $urandom_range(0, 5), $urandom_range(0, 255));
            end
            do_frame($urandom_range(0, 3) == 0);
            do_frame(1'b0);
            test_back_to_back(30);
        end
    endtask

    task automatic test_async_reset();
        dut_reset();
        check_pixel(256, 0, 1'b1, "pre_reset");
        do_write(0, 4, 8'h2A);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rgb !== 6'd0 || rgb_active !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: rgb=%b act=%b expected 0/0", rgb, rgb_active);
        end else
            $display("ok   async reset clears rgb immediately");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        do_frame(1'b1);
        check_pixel(256, 0, 1'b1, "shadow_lost");
    endtask

    initial begin
        test_reset();
        test_basic_render();
        test_scroll_pause();
        test_negative_wrap();
        test_commit_timing();
        test_invalid_write();
        test_dither_and_blank();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
